urt_rx_edge_bit_sampler: RTL
============================

// Module: urt_rx_edge_bit_sampler
// PURPOSE
//  UART RX front end: oversampled edge/bit counting plus 3-sample majority vote per bit.
//  Sits between RX_IN pad and the RX FSM / deserializer stages.
//  Supplies edge_cnt (deserializer shift strobe at edge_cnt==Prescale-1), bit_cnt (FSM frame
//  tracking) and sampled_bit, which must be stable before the deserializer shifts.
// PARAMETERS
//  BIT_CNT_W   4   width of bit counter; saturates at 2**BIT_CNT_W-1
// PORTS
//  CLK_SAMPLER           in   1  oversampling clock (Prescale x baud)
//  RST_SAMPLER           in   1  asynchronous, active-low reset
//  RX_IN_SAMPLER         in   1  serial line, idle high
//  Prescale_SAMPLER      in   5  oversampling ratio; 8 or 16 supported
//  cnt_en_SAMPLER        in   1  from RX FSM: run edge/bit counters
//  samp_en_SAMPLER       in   1  from RX FSM: enable majority sampling
//  edge_cnt_SAMPLER      out  4  edge index inside current bit, 0..Prescale-1
//  bit_cnt_SAMPLER       out  BIT_CNT_W  bit index inside frame
//  sampled_bit_SAMPLER   out  1  majority-voted bit value
//  sample_valid_SAMPLER  out  1  1-cycle pulse: sampled_bit updated this cycle
//  prescale_err_SAMPLER  out  1  Prescale not 8/16
// BEHAVIOUR
//  - Reset (async, RST_SAMPLER=0): edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0,
//    prescale_err=0, internal samples=1. Release mid-frame restarts from edge 0 / bit 0.
//  - prescale_err registered: 1 when Prescale_SAMPLER not in {8,16}; while 1, counters
//    forced to 0, sampled_bit held, sample_valid=0.
//  - Edge counter: cnt_en=1 -> increments each clock; when edge_cnt>=Prescale-1 wraps to 0
//    next clock (>= makes a mid-frame Prescale decrease recover in one cycle).
//  - Bit counter: increments on the clock where edge_cnt wraps; holds at all-ones (no wrap).
//  - cnt_en=0 -> edge_cnt and bit_cnt cleared to 0 next clock (FSM clears between frames).
//  - Sample points, H=Prescale/2: S0 latched at edge_cnt==H-1, S1 at edge_cnt==H;
//    at edge_cnt==H+1 register sampled_bit = maj(S0,S1,rx) = S0&S1 | S0&rx | S1&rx.
//    Prescale 8: edges 3,4,5; Prescale 16: edges 7,8,9.
//  - sampled_bit and sample_valid change on the clock edge ending cycle edge_cnt==H+1 ->
//    visible while edge_cnt==H+2; sample_valid high exactly that one cycle per bit.
//    Stable from edge H+2 through Prescale-1 of same bit, so deserializer shift is safe.
//  - samp_en=0 -> S0/S1/sampled_bit hold, no sample_valid; counters unaffected.
//  - samp_en or cnt_en dropping between H-1 and H+1 aborts that bit's vote: no update,
//    no pulse; partial samples discarded at next edge H-1.
//  - Simultaneous cnt_en=0 and edge wrap: clear wins.
// CONFIGURATION
//  URT_RX_SYNC_EN defined: RX_IN passes a 2-flop synchronizer (reset value 1) before
//    sampling; line-to-sample latency +2 clocks; FSM start detection must allow for it.
//  Not defined: RX_IN_SAMPLER used directly (TB/already-synchronous source only).
// TESTING
//  1 Prescale=8, cnt_en=1 for 24 clks -> edge_cnt 0..7,0..7,0..7; bit_cnt 0,1,2; 3 at clk 24.
//  2 Prescale=16, RX=0 on edges 7,8,9 -> sampled_bit=0, sample_valid pulse at edge_cnt=10.
//  3 Prescale=8, glitch RX=0 only at edge 4 -> sampled_bit stays 1; pulse still at edge 6.
//  4 Prescale=5 -> prescale_err=1, edge_cnt/bit_cnt=0, no pulses; restore 8 -> count resumes.
//  5 cnt_en deasserted at edge_cnt=5,bit_cnt=3 -> both 0 next clk, no pulse that bit.
//  6 RST_SAMPLER low mid-bit (async, no clock edge) -> all outputs at reset values
//    immediately; with URT_RX_SYNC_EN, RX 1->0 reaches vote 2 clks later than without.

Source files
------------

// File: rtl/urt_rx_edge_bit_sampler.sv
// UART RX front end: oversampled edge/bit counters and a 3-sample majority vote per bit.
// Optional URT_RX_SYNC_EN: RX_IN_SAMPLER goes through a 2-flop synchronizer (+2 clocks latency).
module urt_rx_edge_bit_sampler #(
    parameter int BIT_CNT_W = 4
) (
    input  logic                 CLK_SAMPLER,
    input  logic                 RST_SAMPLER,
    input  logic                 RX_IN_SAMPLER,
    input  logic [4:0]           Prescale_SAMPLER,
    input  logic                 cnt_en_SAMPLER,
    input  logic                 samp_en_SAMPLER,
    output logic [3:0]           edge_cnt_SAMPLER,
    output logic [BIT_CNT_W-1:0] bit_cnt_SAMPLER,
    output logic                 sampled_bit_SAMPLER,
    output logic                 sample_valid_SAMPLER,
    output logic                 prescale_err_SAMPLER
);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [3:0]           edge_cnt_r;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic                 sampled_bit_r;
    logic                 sample_valid_r;
    logic                 prescale_err_r;
    logic                 s0_r;
    logic                 s1_r;
    logic [1:0]           arm_r;
    logic                 rx_s;

    logic [4:0]           half_s;
    logic [4:0]           edge5_s;
    logic                 wrap_s;
    logic                 active_s;
    logic                 at_s0_s;
    logic                 at_s1_s;
    logic                 at_vote_s;

`ifdef URT_RX_SYNC_EN
    logic [1:0]           sync_r;

    // Two-stage synchronizer for the asynchronous serial line, idle-high reset value
    always_ff @(posedge CLK_SAMPLER or negedge RST_SAMPLER) begin
        if (!RST_SAMPLER) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], RX_IN_SAMPLER};
        end
    end

    assign rx_s = sync_r[1];
`else
    assign rx_s = RX_IN_SAMPLER;
`endif

    // Sample-point decode; 5-bit compares keep Prescale-1 and H+1 free of overflow
    always_comb begin
        half_s    = {1'b0, Prescale_SAMPLER[4:1]};
        edge5_s   = {1'b0, edge_cnt_r};
        wrap_s    = (edge5_s >= (Prescale_SAMPLER - 5'd1));
        active_s  = samp_en_SAMPLER & cnt_en_SAMPLER & ~prescale_err_r;
        at_s0_s   = (edge5_s == (half_s - 5'd1));
        at_s1_s   = (edge5_s == half_s);
        at_vote_s = (edge5_s == (half_s + 5'd1));
    end

    // Registered Prescale legality flag
    always_ff @(posedge CLK_SAMPLER or negedge RST_SAMPLER) begin
        if (!RST_SAMPLER) begin
            prescale_err_r <= 1'b0;
        end else begin
            prescale_err_r <= !((Prescale_SAMPLER == 5'd8) || (Prescale_SAMPLER == 5'd16));
        end
    end

    // Edge and bit counters; clear has priority over wrap, bit counter saturates
    always_ff @(posedge CLK_SAMPLER or negedge RST_SAMPLER) begin
        if (!RST_SAMPLER) begin
            edge_cnt_r <= 4'd0;
            bit_cnt_r  <= '0;
        end else if (prescale_err_r || !cnt_en_SAMPLER) begin
            edge_cnt_r <= 4'd0;
            bit_cnt_r  <= '0;
        end else if (wrap_s) begin
            edge_cnt_r <= 4'd0;
            if (bit_cnt_r != {BIT_CNT_W{1'b1}}) begin
                bit_cnt_r <= bit_cnt_r + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end else begin
            edge_cnt_r <= edge_cnt_r + 4'd1;
            bit_cnt_r  <= bit_cnt_r;
        end
    end

    // Majority sampler; arm_r tracks an unbroken S0->S1->vote run so an interrupted bit never votes
    always_ff @(posedge CLK_SAMPLER or negedge RST_SAMPLER) begin
        if (!RST_SAMPLER) begin
            s0_r           <= 1'b1;
            s1_r           <= 1'b1;
            arm_r          <= 2'b00;
            sampled_bit_r  <= 1'b1;
            sample_valid_r <= 1'b0;
        end else begin
            sample_valid_r <= 1'b0;
            if (!active_s) begin
                arm_r <= 2'b00;
            end else if (at_s0_s) begin
                s0_r  <= rx_s;
                arm_r <= 2'b01;
            end else if (at_s1_s) begin
                s1_r  <= rx_s;
                arm_r <= {arm_r[0], 1'b0};
            end else if (at_vote_s) begin
                if (arm_r[1]) begin
                    sampled_bit_r  <= maj3(s0_r, s1_r, rx_s);
                    sample_valid_r <= 1'b1;
                end else begin
                    sampled_bit_r  <= sampled_bit_r;
                end
                arm_r <= 2'b00;
            end else begin
                arm_r <= arm_r;
            end
        end
    end

    assign edge_cnt_SAMPLER     = edge_cnt_r;
    assign bit_cnt_SAMPLER      = bit_cnt_r;
    assign sampled_bit_SAMPLER  = sampled_bit_r;
    assign sample_valid_SAMPLER = sample_valid_r;
    assign prescale_err_SAMPLER = prescale_err_r;

endmodule
